// File: rtl/rrat_retire_pkg.sv
// Shared retirement-RAT constants: register-file sizes, index widths, zero reg, FIFO pointer helper.
// Sizes come from the project-wide PROJ_NUM_ARCH_REGS / PROJ_NUM_PHYS_REGS macros when they are defined.
`ifndef PROJ_NUM_ARCH_REGS
`define PROJ_NUM_ARCH_REGS 32
`endif
`ifndef PROJ_NUM_PHYS_REGS
`define PROJ_NUM_PHYS_REGS 64
`endif

package rrat_retire_pkg;
  localparam int RRAT_NUM_ARCH_REGS   = `PROJ_NUM_ARCH_REGS;
  localparam int RRAT_NUM_PHYS_REGS   = `PROJ_NUM_PHYS_REGS;
  localparam int RRAT_FREE_FIFO_DEPTH = 8;
  localparam int LOG_ARCH             = $clog2(RRAT_NUM_ARCH_REGS);
  localparam int LOG_PHYS             = $clog2(RRAT_NUM_PHYS_REGS);
  localparam int RRAT_ZERO_REG        = 0;

  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/rrat_retire_free_reg_fifo.sv
// Synchronous FIFO holding freed physical registers; DEPTH must be a power of two so pointers wrap naturally.
// Head is registered data (zero while empty); a pop while empty is dropped, a push while full is dropped unless a pop frees the slot.
module free_reg_fifo
  import rrat_retire_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_dat,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head,
  output logic [fifo_ptr_w(DEPTH):0]    count,
  output logic                          full,
  output logic                          empty
);
  localparam int PW = fifo_ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (cnt_q == (PW+1)'(DEPTH));
    empty   = (cnt_q == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = empty ? '0 : mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/rrat_retire.sv
// Retirement RAT: committed arch->phys map, commit counter, and the FIFO returning displaced phys regs to rename.
// Optional consistency checker compiled in with macro RRAT_CHECK_EN; otherwise Error_OUT is tied low.
module rrat_retire
  import rrat_retire_pkg::*;
#(
  parameter int NUM_ARCH_REGS   = RRAT_NUM_ARCH_REGS,
  parameter int NUM_PHYS_REGS   = RRAT_NUM_PHYS_REGS,
  parameter int FREE_FIFO_DEPTH = RRAT_FREE_FIFO_DEPTH
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             ReadyCommit_IN,
  input  logic                             RegUpdate_IN,
  input  logic [$clog2(NUM_ARCH_REGS)-1:0] Arch_reg_IN,
  input  logic [$clog2(NUM_PHYS_REGS)-1:0] Phys_reg_IN,
  output logic                             Stall_OUT,
  output logic                             Free_valid_OUT,
  output logic [$clog2(NUM_PHYS_REGS)-1:0] Free_reg_OUT,
  input  logic                             Free_ready_IN,
  input  logic [$clog2(NUM_ARCH_REGS)-1:0] Map_rd_arch_IN,
  output logic [$clog2(NUM_PHYS_REGS)-1:0] Map_rd_phys_OUT,
  output logic [31:0]                      Commit_count_OUT,
  output logic                             Error_OUT
);
  localparam int LA = $clog2(NUM_ARCH_REGS);
  localparam int LP = $clog2(NUM_PHYS_REGS);
  localparam int PW = fifo_ptr_w(FREE_FIFO_DEPTH);

  logic [LP-1:0] map_q [NUM_ARCH_REGS];
  logic [LP-1:0] map_d [NUM_ARCH_REGS];
  logic [31:0]   cnt_q, cnt_d;
  logic          accept, upd, push;
  logic [LP-1:0] old_phys, push_dat;
  logic [PW:0]   fifo_count;
  logic          fifo_full, fifo_empty;

  always_comb begin
    map_d    = map_q;
    cnt_d    = cnt_q;
    accept   = ReadyCommit_IN && !fifo_full;
    upd      = accept && RegUpdate_IN;
    old_phys = map_q[Arch_reg_IN];
    push     = 1'b0;
    push_dat = Phys_reg_IN;
    if (accept) begin
      cnt_d = cnt_q + 32'd1;
    end
    if (upd) begin
      push = 1'b1;
      // A write to the zero reg never lands; the new phys reg goes straight back.
      if (Arch_reg_IN != LA'(RRAT_ZERO_REG)) begin
        map_d[Arch_reg_IN] = Phys_reg_IN;
        push_dat           = old_phys;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) map_q[i] <= LP'(i);
      cnt_q <= '0;
    end else begin
      map_q <= map_d;
      cnt_q <= cnt_d;
    end
  end

  free_reg_fifo #(
    .WIDTH (LP),
    .DEPTH (FREE_FIFO_DEPTH)
  ) u_free_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .push     (push),
    .push_dat (push_dat),
    .pop      (Free_ready_IN),
    .head     (Free_reg_OUT),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign Stall_OUT        = (fifo_count == (PW+1)'(FREE_FIFO_DEPTH));
  assign Free_valid_OUT   = !fifo_empty;
  assign Map_rd_phys_OUT  = map_q[Map_rd_arch_IN];
  assign Commit_count_OUT = cnt_q;

`ifdef RRAT_CHECK_EN
  logic err_q, err_d, flag;

  always_comb begin
    flag = 1'b0;
    if (upd) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        if ((LA'(i) != Arch_reg_IN) && (map_q[i] == Phys_reg_IN)) flag = 1'b1;
      end
      if (Phys_reg_IN == old_phys) flag = 1'b1;
      if (int'(Phys_reg_IN) >= NUM_PHYS_REGS) flag = 1'b1;
    end
    err_d = err_q | flag;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (flag) $display("RRAT: ERROR arch=%0d phys=%0d old=%0d", Arch_reg_IN, Phys_reg_IN, old_phys);
    end
  end

  assign Error_OUT = err_q;
`else
  assign Error_OUT = 1'b0;
`endif
endmodule

// File: tb/tb_rrat_retire.sv
// Directed bench for rrat_retire: vector table for commit/stall flow plus hand sequences for corner cases.
module tb_rrat_retire;
  import rrat_retire_pkg::*;
  localparam int LA = $clog2(RRAT_NUM_ARCH_REGS);
  localparam int LP = $clog2(RRAT_NUM_PHYS_REGS);
`ifdef RRAT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          ReadyCommit_IN, RegUpdate_IN, Free_ready_IN;
  logic [LA-1:0] Arch_reg_IN, Map_rd_arch_IN;
  logic [LP-1:0] Phys_reg_IN;
  logic          Stall_OUT, Free_valid_OUT, Error_OUT;
  logic [LP-1:0] Free_reg_OUT, Map_rd_phys_OUT;
  logic [31:0]   Commit_count_OUT;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  rrat_retire dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .ReadyCommit_IN   (ReadyCommit_IN),
    .RegUpdate_IN     (RegUpdate_IN),
    .Arch_reg_IN      (Arch_reg_IN),
    .Phys_reg_IN      (Phys_reg_IN),
    .Stall_OUT        (Stall_OUT),
    .Free_valid_OUT   (Free_valid_OUT),
    .Free_reg_OUT     (Free_reg_OUT),
    .Free_ready_IN    (Free_ready_IN),
    .Map_rd_arch_IN   (Map_rd_arch_IN),
    .Map_rd_phys_OUT  (Map_rd_phys_OUT),
    .Commit_count_OUT (Commit_count_OUT),
    .Error_OUT        (Error_OUT)
  );

  typedef struct {
    bit rst; bit cmt; bit upd; int arch; int phys; bit frdy; int rd;
    bit stall; bit fvld; int freg; int rdp; int cnt;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit cmt, input bit upd, input int arch, input int phys,
                       input bit frdy, input int rd);
    ReadyCommit_IN = cmt;
    RegUpdate_IN   = upd;
    Arch_reg_IN    = LA'(arch);
    Phys_reg_IN    = LP'(phys);
    Free_ready_IN  = frdy;
    Map_rd_arch_IN = LA'(rd);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    RESET = 1'b0;
    step();
    RESET = 1'b1;
  endtask

  initial begin
    // Fields: rst cmt upd arch phys frdy rd | stall fvld freg rdp cnt
    tbl[0]  = '{0, 1, 1, 3, 40, 0, 3, 0, 1, 3, 40, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 40, 1};
    for (int k = 1; k <= 8; k++)
      tbl[k+1] = '{(k == 1), 1, 1, k, 39 + k, 0, k, (k == 8), 1, 1, 39 + k, k};
    tbl[10] = '{0, 1, 1, 9, 48, 0, 9, 1, 1, 1, 9, 8};
    tbl[11] = '{0, 1, 1, 9, 48, 1, 9, 0, 1, 2, 9, 8};
    tbl[12] = '{0, 1, 1, 9, 48, 0, 9, 1, 1, 2, 48, 9};
    tbl[13] = '{0, 1, 0, 9, 55, 1, 9, 0, 1, 3, 48, 9};
    tbl[14] = '{0, 1, 0, 9, 55, 0, 9, 0, 1, 3, 48, 10};

    drive(0, 0, 0, 0, 0, 5);
    #12;
    chk("rst_map5", 32'(Map_rd_phys_OUT), 5);
    chk("rst_fvld", 32'(Free_valid_OUT), 0);
    chk("rst_freg", 32'(Free_reg_OUT), 0);
    chk("rst_stall", 32'(Stall_OUT), 0);
    chk("rst_cnt", Commit_count_OUT, 0);
    chk("rst_err", 32'(Error_OUT), 0);
    RESET = 1'b1;

    drive(0, 0, 0, 0, 1, 5);
    step();
    chk("empty_pop_fvld", 32'(Free_valid_OUT), 0);
    chk("empty_pop_stall", 32'(Stall_OUT), 0);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].cmt, tbl[i].upd, tbl[i].arch, tbl[i].phys, tbl[i].frdy, tbl[i].rd);
      step();
      chk($sformatf("v%0d_stall", i), 32'(Stall_OUT), 32'(tbl[i].stall));
      chk($sformatf("v%0d_fvld", i), 32'(Free_valid_OUT), 32'(tbl[i].fvld));
      chk($sformatf("v%0d_freg", i), 32'(Free_reg_OUT), tbl[i].freg);
      chk($sformatf("v%0d_map", i), 32'(Map_rd_phys_OUT), tbl[i].rdp);
      chk($sformatf("v%0d_cnt", i), Commit_count_OUT, tbl[i].cnt);
      chk($sformatf("v%0d_err", i), 32'(Error_OUT), 0);
    end

    // Zero-reg commit, back-to-back same-reg commits, FIFO ordering.
    do_reset();
    drive(1, 1, 0, 50, 0, 0);
    step();
    chk("zero_map0", 32'(Map_rd_phys_OUT), 0);
    chk("zero_freg", 32'(Free_reg_OUT), 50);
    chk("zero_fvld", 32'(Free_valid_OUT), 1);
    drive(1, 1, 7, 41, 0, 7);
    step();
    drive(1, 1, 7, 42, 0, 7);
    step();
    chk("b2b_map7", 32'(Map_rd_phys_OUT), 42);
    chk("b2b_cnt", Commit_count_OUT, 3);
    chk("b2b_head", 32'(Free_reg_OUT), 50);
    drive(0, 0, 0, 0, 1, 7);
    step();
    chk("b2b_pop1", 32'(Free_reg_OUT), 7);
    step();
    chk("b2b_pop2", 32'(Free_reg_OUT), 41);
    drive(1, 1, 4, 60, 1, 4);
    step();
    chk("pushpop_freg", 32'(Free_reg_OUT), 4);
    chk("pushpop_fvld", 32'(Free_valid_OUT), 1);
    chk("pushpop_map4", 32'(Map_rd_phys_OUT), 60);
    drive(1, 1, 5, 61, 0, 5);
    step();
    drive(1, 1, 6, 62, 0, 7);
    step();
    chk("pre_rst_freg", 32'(Free_reg_OUT), 4);
    chk("pre_rst_cnt", Commit_count_OUT, 6);

    // Asynchronous reset between clock edges with three entries queued.
    drive(0, 0, 0, 0, 0, 7);
    RESET = 1'b0;
    #1;
    chk("arst_fvld", 32'(Free_valid_OUT), 0);
    chk("arst_freg", 32'(Free_reg_OUT), 0);
    chk("arst_map7", 32'(Map_rd_phys_OUT), 7);
    chk("arst_cnt", Commit_count_OUT, 0);
    chk("arst_stall", 32'(Stall_OUT), 0);
    #1;
    RESET = 1'b1;

    // Duplicate phys mapping: arch1 and arch2 both pointing at 41.
    drive(1, 1, 1, 41, 1, 2);
    step();
    chk("dup_err0", 32'(Error_OUT), 0);
    drive(1, 1, 2, 41, 1, 2);
    step();
    chk("dup_map2", 32'(Map_rd_phys_OUT), 41);
    chk("dup_err1", 32'(Error_OUT), 32'(EXP_ERR));
    drive(0, 0, 0, 0, 1, 2);
    step();
    step();
    chk("dup_err_sticky", 32'(Error_OUT), 32'(EXP_ERR));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
